// File: rtl/aplic_pkg.sv
// Shared source-mode definitions for the APLIC interrupt-source front end.
// Encodings follow the AIA sourcecfg SM field; 2 and 3 are reserved and behave as INACTIVE.
package aplic_pkg;

  localparam int SM_W = 3;

  typedef enum logic [SM_W-1:0] {
    SM_INACTIVE = 3'd0,
    SM_DETACHED = 3'd1,
    SM_RSVD2    = 3'd2,
    SM_RSVD3    = 3'd3,
    SM_EDGE1    = 3'd4,
    SM_EDGE0    = 3'd5,
    SM_LEVEL1   = 3'd6,
    SM_LEVEL0   = 3'd7
  } sm_e;

  function automatic logic is_edge(input logic [SM_W-1:0] sm);
    return (sm == SM_EDGE1) || (sm == SM_EDGE0);
  endfunction

  function automatic logic is_level(input logic [SM_W-1:0] sm);
    return (sm == SM_LEVEL1) || (sm == SM_LEVEL0);
  endfunction

  // Inverting modes present an active-low wire as active-high to the domain.
  function automatic logic rectify(input logic [SM_W-1:0] sm, input logic level);
    logic res;
    res = 1'b0;
    case (sm)
      SM_EDGE1, SM_LEVEL1: res = level;
      SM_EDGE0, SM_LEVEL0: res = ~level;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/aplic_src_filter.sv
// One interrupt line: multi-flop synchroniser followed by an optional stable-count glitch filter.
// A new level is accepted only after it has been seen for FILTER_LEN consecutive cycles.
module aplic_src_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    assign o_filt = sync_out;
  end else begin : g_filter
    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (sync_out == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync_out;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign o_filt = filt_q;
  end

endmodule

// File: rtl/aplic_irq_frontend.sv
// Interrupt-source front end: per-line sync/filter, source-mode rectification and edge pulse.
// Source 0 is reserved and permanently reads as inactive.
module aplic_irq_frontend
  import aplic_pkg::*;
#(
  parameter int NR_SRC      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NR_SRC-1:0]      i_irq_sources,
  input  logic [SM_W*NR_SRC-1:0] i_sourcecfg_sm,
  output logic [NR_SRC-1:0]      o_rectified,
  output logic [NR_SRC-1:0]      o_edge_set
);

  logic [NR_SRC-1:0]           filt;
  logic [NR_SRC-1:0]           rect_next;
  logic [NR_SRC-1:0]           edge_next;
  logic [NR_SRC-1:0]           rect_q;
  logic [NR_SRC-1:0]           edge_q;
  logic [SM_W*NR_SRC-1:SM_W]   sm_q;
  logic                        unused_src0;

  assign unused_src0 = ^{i_irq_sources[0], i_sourcecfg_sm[SM_W-1:0]};
  assign filt[0]     = 1'b0;

  for (genvar n = 1; n < NR_SRC; n++) begin : g_src
    aplic_src_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_line (i_irq_sources[n]),
      .o_filt (filt[n])
    );
  end

  // A mode change reseeds the edge history, so reconfiguring never looks like an edge.
  always_comb begin
    rect_next = '0;
    edge_next = '0;
    for (int n = 1; n < NR_SRC; n++) begin
      rect_next[n] = rectify(i_sourcecfg_sm[SM_W*n +: SM_W], filt[n]);
      edge_next[n] = is_edge(i_sourcecfg_sm[SM_W*n +: SM_W])
                   & rect_next[n]
                   & ~rect_q[n]
                   & (i_sourcecfg_sm[SM_W*n +: SM_W] == sm_q[SM_W*n +: SM_W]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rect_q <= '0;
      edge_q <= '0;
      sm_q   <= '0;
    end else begin
      rect_q <= rect_next;
      edge_q <= edge_next;
      sm_q   <= i_sourcecfg_sm[SM_W*NR_SRC-1:SM_W];
    end
  end

  assign o_rectified = rect_q;
  assign o_edge_set  = edge_q;

endmodule
